// File: rtl/uart_rx_pkg.sv
// Shared types and helpers for the UART receive / frame loader path.
package uart_rx_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_e;

    typedef enum logic {
        F_IDLE,
        F_RECV
    } frame_state_e;

    // Number of pixels in one frame; sizes the pixel counter's terminal value.
    function automatic int unsigned frame_pixels(input int unsigned img_width,
                                                 input int unsigned img_height);
        return img_width * img_height;
    endfunction

endpackage

// File: rtl/uart_rx_core.sv
// Oversampled UART byte receiver: 2-flop synchroniser, bit FSM, byte/error strobes.
module uart_rx_core
    import uart_rx_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned SAMPLING   = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  b_tick_i,
    input  logic                  rx_i,
    output logic                  busy_o,
    output logic                  byte_valid_o,
    output logic                  frame_error_o,
    output logic [DATA_WIDTH-1:0] data_o
);

    localparam int unsigned TICK_W = $clog2(SAMPLING);
    localparam int unsigned BIT_W  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [TICK_W-1:0] MID_TICK  = TICK_W'(SAMPLING / 2 - 1);
    localparam logic [TICK_W-1:0] LAST_TICK = TICK_W'(SAMPLING - 1);
    localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(DATA_WIDTH - 1);

    logic                  rx_meta_q;
    logic                  rx_sync_q;
    rx_state_e             state_q;
    logic [TICK_W-1:0]     tick_q;
    logic [BIT_W-1:0]      bit_q;
    logic [DATA_WIDTH-1:0] shift_q;
    logic [DATA_WIDTH-1:0] shift_d;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  busy_q;
    logic                  valid_q;
    logic                  ferr_q;
    logic                  brk_q;

    // LSB-first: each new sample enters at the MSB and shifts right.
    if (DATA_WIDTH > 1) begin : g_shift_wide
        assign shift_d = {rx_sync_q, shift_q[DATA_WIDTH-1:1]};
    end else begin : g_shift_narrow
        assign shift_d = rx_sync_q;
    end

    // Two-flop synchroniser for the asynchronous line; idles high.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= rx_i;
            rx_sync_q <= rx_meta_q;
        end
    end

    // Bit FSM: start qualification at mid-start, mid-bit data sampling, stop check.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            tick_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            brk_q   <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    // After a framing error the line must return high before a new start.
                    if (brk_q) begin
                        if (rx_sync_q) begin
                            brk_q <= 1'b0;
                        end
                    end else if (!rx_sync_q) begin
                        state_q <= START;
                        tick_q  <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                START: begin
                    if (b_tick_i) begin
                        if (tick_q == MID_TICK) begin
                            if (rx_sync_q) begin
                                state_q <= IDLE;
                                busy_q  <= 1'b0;
                            end else begin
                                state_q <= DATA;
                                tick_q  <= '0;
                                bit_q   <= '0;
                            end
                        end else begin
                            tick_q <= tick_q + TICK_W'(1);
                        end
                    end
                end
                DATA: begin
                    if (b_tick_i) begin
                        if (tick_q == LAST_TICK) begin
                            tick_q  <= '0;
                            shift_q <= shift_d;
                            if (bit_q == LAST_BIT) begin
                                state_q <= STOP;
                            end else begin
                                bit_q <= bit_q + BIT_W'(1);
                            end
                        end else begin
                            tick_q <= tick_q + TICK_W'(1);
                        end
                    end
                end
                STOP: begin
                    if (b_tick_i) begin
                        if (tick_q == LAST_TICK) begin
                            state_q <= IDLE;
                            tick_q  <= '0;
                            busy_q  <= 1'b0;
                            if (rx_sync_q) begin
                                valid_q <= 1'b1;
                                data_q  <= shift_q;
                            end else begin
                                ferr_q <= 1'b1;
                                brk_q  <= 1'b1;
                            end
                        end else begin
                            tick_q <= tick_q + TICK_W'(1);
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy_o        = busy_q;
    assign byte_valid_o  = valid_q;
    assign frame_error_o = ferr_q;
    assign data_o        = data_q;

endmodule

// File: rtl/uart_rx_frame_loader.sv
// UART receive path that loads one raster-ordered grayscale frame into the frame buffer.
module uart_rx_frame_loader
    import uart_rx_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned IMG_WIDTH  = 176,
    parameter int unsigned IMG_HEIGHT = 240,
    parameter int unsigned SAMPLING   = 16,
    parameter int unsigned ADDR_WIDTH = $clog2(IMG_WIDTH * IMG_HEIGHT)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  b_tick,
    input  logic                  rx_arm,
    input  logic                  rx,
    output logic                  fb_we,
    output logic [ADDR_WIDTH-1:0] fb_wAddr,
    output logic [DATA_WIDTH-1:0] fb_wData,
    output logic                  rx_busy,
    output logic                  receiving,
    output logic                  frame_rx_done,
    output logic                  frame_err
);

    localparam int unsigned FRAME_PIXELS = frame_pixels(IMG_WIDTH, IMG_HEIGHT);
    localparam logic [ADDR_WIDTH-1:0] LAST_PIX = ADDR_WIDTH'(FRAME_PIXELS - 1);

    logic                  byte_valid;
    logic                  byte_err;
    logic [DATA_WIDTH-1:0] byte_data;

    frame_state_e          fstate_q;
    logic [ADDR_WIDTH-1:0] pix_q;
    logic [ADDR_WIDTH-1:0] pix_d;
    logic                  last_q;
    logic                  fb_we_q;
    logic [ADDR_WIDTH-1:0] fb_waddr_q;
    logic [DATA_WIDTH-1:0] fb_wdata_q;
    logic                  receiving_q;
    logic                  done_q;
    logic                  ferr_q;

    uart_rx_core #(
        .DATA_WIDTH (DATA_WIDTH),
        .SAMPLING   (SAMPLING)
    ) u_core (
        .clk           (clk),
        .reset         (reset),
        .b_tick_i      (b_tick),
        .rx_i          (rx),
        .busy_o        (rx_busy),
        .byte_valid_o  (byte_valid),
        .frame_error_o (byte_err),
        .data_o        (byte_data)
    );

    assign pix_d = pix_q + ADDR_WIDTH'(1);

    // Frame FSM: arm, write each valid byte at the running pixel address, flag done.
    always_ff @(posedge clk) begin
        if (reset) begin
            fstate_q    <= F_IDLE;
            pix_q       <= '0;
            last_q      <= 1'b0;
            fb_we_q     <= 1'b0;
            fb_waddr_q  <= '0;
            fb_wdata_q  <= '0;
            receiving_q <= 1'b0;
            done_q      <= 1'b0;
            ferr_q      <= 1'b0;
        end else begin
            fb_we_q <= 1'b0;
            done_q  <= 1'b0;
            // Sticky; an arm in the same cycle clears it below.
            if (byte_err) begin
                ferr_q <= 1'b1;
            end
            case (fstate_q)
                F_IDLE: begin
                    if (rx_arm) begin
                        fstate_q    <= F_RECV;
                        pix_q       <= '0;
                        receiving_q <= 1'b1;
                        ferr_q      <= 1'b0;
                    end
                end
                F_RECV: begin
                    if (last_q) begin
                        last_q      <= 1'b0;
                        done_q      <= 1'b1;
                        receiving_q <= 1'b0;
                        pix_q       <= '0;
                        fstate_q    <= F_IDLE;
                    end else if (byte_valid) begin
                        fb_we_q    <= 1'b1;
                        fb_waddr_q <= pix_q;
                        fb_wdata_q <= byte_data;
                        if (pix_q == LAST_PIX) begin
                            last_q <= 1'b1;
                        end else begin
                            pix_q <= pix_d;
                        end
                    end
                end
                default: begin
                    fstate_q <= F_IDLE;
                end
            endcase
        end
    end

    assign fb_we         = fb_we_q;
    assign fb_wAddr      = fb_waddr_q;
    assign fb_wData      = fb_wdata_q;
    assign receiving     = receiving_q;
    assign frame_rx_done = done_q;
    assign frame_err     = ferr_q;

endmodule

// File: tb/tb_uart_rx_frame_loader.sv
// Scoreboard bench for uart_rx_frame_loader with a 4x2 frame and 16x oversampling.
module tb_uart_rx_frame_loader;

    localparam int unsigned IMG_W  = 4;
    localparam int unsigned IMG_H  = 2;
    localparam int unsigned NPIX   = IMG_W * IMG_H;
    localparam int unsigned SAMP   = 16;
    localparam int unsigned AW     = 3;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [7:0]    data;
    } wr_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          b_tick = 1'b0;
    logic          rx_arm = 1'b0;
    logic          rx = 1'b1;
    logic          fb_we;
    logic [AW-1:0] fb_wAddr;
    logic [7:0]    fb_wData;
    logic          rx_busy;
    logic          receiving;
    logic          frame_rx_done;
    logic          frame_err;

    int n_tests = 0;
    int n_fail  = 0;
    int tdiv    = 0;

    wr_t exp_q[$];
    int  done_cnt  = 0;
    int  exp_done  = 0;
    bit  m_armed   = 1'b0;
    int  m_addr    = 0;
    bit  m_err     = 1'b0;

    logic busy_h1 = 1'b0;
    logic busy_h2 = 1'b0;
    logic we_h1   = 1'b0;

    uart_rx_frame_loader #(
        .DATA_WIDTH (8),
        .IMG_WIDTH  (IMG_W),
        .IMG_HEIGHT (IMG_H),
        .SAMPLING   (SAMP),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .b_tick        (b_tick),
        .rx_arm        (rx_arm),
        .rx            (rx),
        .fb_we         (fb_we),
        .fb_wAddr      (fb_wAddr),
        .fb_wData      (fb_wData),
        .rx_busy       (rx_busy),
        .receiving     (receiving),
        .frame_rx_done (frame_rx_done),
        .frame_err     (frame_err)
    );

    always #5 clk = ~clk;

    // One-clk b_tick every 4 clocks.
    always @(posedge clk) begin
        tdiv   <= (tdiv == 3) ? 0 : tdiv + 1;
        b_tick <= (tdiv == 2);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Write monitor: pop the scoreboard on every strobe, also checks latencies.
    always @(negedge clk) begin
        if (!reset) begin
            if (fb_we) begin
                if (exp_q.size() == 0) begin
                    check("spurious_we", 32'(fb_wAddr), 32'hFFFF_FFFF);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    check("wr_addr", 32'(fb_wAddr), 32'(e.addr));
                    check("wr_data", 32'(fb_wData), 32'(e.data));
                    check("we_after_stop", 32'({busy_h2, busy_h1}), 32'h2);
                end
            end
            if (frame_rx_done) begin
                done_cnt++;
                check("done_after_last_we", 32'(we_h1), 32'h1);
            end
        end
        busy_h2 = busy_h1;
        busy_h1 = rx_busy;
        we_h1   = fb_we;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_ticks(input int n);
        repeat (n) begin
            @(posedge clk);
            while (b_tick !== 1'b1) @(posedge clk);
        end
    endtask

    task automatic drive_bit(input logic v);
        @(posedge clk);
        #1 rx = v;
        wait_ticks(SAMP);
    endtask

    // Sends one character; the model predicts whether it becomes a write.
    task automatic send_byte(input logic [7:0] d, input logic stop);
        if (!stop) begin
            m_err = 1'b1;
        end else if (m_armed) begin
            exp_q.push_back('{addr: AW'(m_addr), data: d});
            m_addr++;
            if (m_addr == NPIX) begin
                m_armed = 1'b0;
                m_addr  = 0;
                exp_done++;
            end
        end
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(stop);
        drive_bit(1'b1);
    endtask

    task automatic arm();
        @(posedge clk);
        #1 rx_arm = 1'b1;
        @(posedge clk);
        #1 rx_arm = 1'b0;
        if (!m_armed) begin
            m_armed = 1'b1;
            m_addr  = 0;
            m_err   = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 reset = 1'b1;
        rx = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        m_armed = 1'b0;
        m_addr  = 0;
        m_err   = 1'b0;
        exp_q.delete();
        wait_ticks(4);
    endtask

    task automatic check_state(input string tag);
        @(negedge clk);
        check({tag, "_receiving"}, 32'(receiving), 32'(m_armed));
        check({tag, "_frame_err"}, 32'(frame_err), 32'(m_err));
        check({tag, "_done_cnt"}, 32'(done_cnt), 32'(exp_done));
        check({tag, "_pending"}, 32'(exp_q.size()), 32'h0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_we"}, 32'(fb_we), 32'h0);
        check({tag, "_addr"}, 32'(fb_wAddr), 32'h0);
        check({tag, "_data"}, 32'(fb_wData), 32'h0);
        check({tag, "_busy"}, 32'(rx_busy), 32'h0);
        check({tag, "_receiving"}, 32'(receiving), 32'h0);
        check({tag, "_done"}, 32'(frame_rx_done), 32'h0);
        check({tag, "_err"}, 32'(frame_err), 32'h0);
    endtask

    initial begin
        // Reset state
        repeat (4) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("por");
        @(posedge clk);
        #1 reset = 1'b0;
        wait_ticks(4);

        // Single byte
        arm();
        send_byte(8'hA5, 1'b1);
        check_state("single");

        // Full frame, then an excess byte that must be dropped
        do_reset();
        arm();
        for (int i = 0; i < NPIX; i++) send_byte(8'(i), 1'b1);
        check_state("frame");
        send_byte(8'hEE, 1'b1);
        check_state("excess");

        // Framing error in the middle of a capture
        do_reset();
        arm();
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b1);
        check_state("ferr");
        wait_ticks(40);
        check_state("ferr_hold");

        // Glitch and unarmed byte
        do_reset();
        @(posedge clk);
        #1 rx = 1'b0;
        wait_ticks(6);
        @(posedge clk);
        #1 rx = 1'b1;
        wait_ticks(6);
        @(negedge clk);
        check("glitch_busy", 32'(rx_busy), 32'h0);
        send_byte(8'h5A, 1'b1);
        check_state("unarmed");

        // Reset in the middle of a byte
        do_reset();
        arm();
        send_byte(8'h81, 1'b1);
        send_byte(8'h92, 1'b1);
        send_byte(8'hA3, 1'b1);
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        @(posedge clk);
        #1 reset = 1'b1;
        rx = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("midreset");
        @(posedge clk);
        #1 reset = 1'b0;
        m_armed = 1'b0;
        m_addr  = 0;
        m_err   = 1'b0;
        exp_q.delete();
        wait_ticks(4);
        arm();
        send_byte(8'hC3, 1'b1);
        check_state("rearm");

        // Second arm mid-frame is ignored
        do_reset();
        arm();
        for (int i = 0; i < 4; i++) send_byte(8'h40 + 8'(i), 1'b1);
        arm();
        for (int i = 4; i < NPIX; i++) send_byte(8'h40 + 8'(i), 1'b1);
        send_byte(8'h77, 1'b1);
        check_state("double_arm");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
